ntt_bram_sched: RTL and testbench

- In-place radix-2 NTT scheduler for the 18-bit x 2^LOGN coefficient BRAM (registered-address, one write port, one read port).
- Sequences all LOGN stages of butterflies: issues BRAM read addresses, tags operands for the external butterfly pipeline, and replays the delayed addresses as write-back addresses.
- When idle, the BRAM ports are handed to the host load/unload path.

---
 rtl/ntt_bram_sched.sv | 170 +++++++++++++++++
 tb/tb_ntt_bram_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bram_sched.sv
// rtl/ntt_bram_sched.sv - in-place radix-2 NTT scheduler for a single-port-pair coefficient BRAM
// Walks LOGN stages of butterflies, tags operands for the butterfly pipe and replays addresses as write-backs.
module ntt_bram_sched #(
  parameter int LOGN   = 9,
  parameter int BF_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      host_wr_en,
  input  logic [LOGN-1:0]           host_wr_addr,
  input  logic [LOGN-1:0]           host_rd_addr,
  output logic                      bram_wr_en,
  output logic [LOGN-1:0]           bram_wr_addr,
  output logic [LOGN-1:0]           bram_rd_addr,
  output logic                      bf_in_valid,
  output logic                      bf_in_sel,
  output logic [LOGN-2:0]           bf_tw_idx,
  output logic [$clog2(LOGN)-1:0]   bf_stage
);

  localparam int SW = $clog2(LOGN);
  localparam int DW = $clog2(BF_LAT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [SW-1:0]   stage_q;
  logic [LOGN-2:0] j_q;
  logic            phase_q;
  logic [DW-1:0]   drain_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_vld_q;
  logic            rd_sel_q;
  logic [LOGN-1:0] rd_addr_q;
  logic [LOGN-2:0] rd_tw_q;

  logic            bf_vld_q;
  logic            bf_sel_q;
  logic [LOGN-2:0] bf_tw_q;
  logic [SW-1:0]   bf_stage_q;
  logic [LOGN-1:0] dl_addr_q [BF_LAT+1];
  logic [BF_LAT:0] dl_vld_q;

  logic [LOGN-2:0] j_d;
  logic            phase_d;
  logic [LOGN-1:0] j_ext;
  logic [LOGN-1:0] mask;
  logic [LOGN-1:0] addr_d;
  logic [LOGN-2:0] tw_d;
  logic            last_rd;
  logic            last_stage;
  logic            drain_end;

  // mask = half-1; clearing the offset bits and shifting left by one yields group*2*half
  assign j_d        = phase_q ? j_q + 1'b1 : j_q;
  assign phase_d    = ~phase_q;
  assign j_ext      = {1'b0, j_d};
  assign mask       = (LOGN'(1) << (LOGN - 1 - int'(stage_q))) - LOGN'(1);
  assign addr_d     = ((j_ext & ~mask) << 1) | (j_ext & mask)
                    | (phase_d ? (mask + LOGN'(1)) : '0);
  assign tw_d       = (j_d & mask[LOGN-2:0]) << stage_q;
  assign last_rd    = phase_q && (j_q == '1);
  assign last_stage = (stage_q == SW'(LOGN - 1));
  assign drain_end  = (drain_q == DW'(BF_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      j_q       <= '0;
      phase_q   <= 1'b0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_tw_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            stage_q   <= '0;
            j_q       <= '0;
            phase_q   <= 1'b0;
            rd_vld_q  <= 1'b1;
            rd_sel_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_tw_q   <= '0;
          end
        end
        ISSUE: begin
          if (last_rd) begin
            state_q  <= DRAIN;
            drain_q  <= '0;
            rd_vld_q <= 1'b0;
          end else begin
            j_q       <= j_d;
            phase_q   <= phase_d;
            rd_sel_q  <= phase_d;
            rd_addr_q <= addr_d;
            rd_tw_q   <= tw_d;
          end
        end
        DRAIN: begin
          // wait for the last write-back of this stage before reading the next one
          if (drain_end) begin
            if (last_stage) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              stage_q   <= stage_q + 1'b1;
              j_q       <= '0;
              phase_q   <= 1'b0;
              rd_vld_q  <= 1'b1;
              rd_sel_q  <= 1'b0;
              rd_addr_q <= '0;
              rd_tw_q   <= '0;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_vld_q   <= 1'b0;
      bf_sel_q   <= 1'b0;
      bf_tw_q    <= '0;
      bf_stage_q <= '0;
      dl_vld_q   <= '0;
      for (int i = 0; i <= BF_LAT; i++) dl_addr_q[i] <= '0;
    end else begin
      bf_vld_q     <= rd_vld_q;
      bf_sel_q     <= rd_sel_q;
      bf_tw_q      <= rd_tw_q;
      bf_stage_q   <= stage_q;
      dl_vld_q     <= {dl_vld_q[BF_LAT-1:0], rd_vld_q};
      dl_addr_q[0] <= rd_addr_q;
      for (int i = 1; i <= BF_LAT; i++) dl_addr_q[i] <= dl_addr_q[i-1];
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bram_wr_en   = busy_q ? dl_vld_q[BF_LAT]  : host_wr_en;
  assign bram_wr_addr = busy_q ? dl_addr_q[BF_LAT] : host_wr_addr;
  assign bram_rd_addr = busy_q ? rd_addr_q         : host_rd_addr;
  assign bf_in_valid  = bf_vld_q;
  assign bf_in_sel    = bf_sel_q;
  assign bf_tw_idx    = bf_tw_q;
  assign bf_stage     = bf_stage_q;

endmodule

// File: tb/tb_ntt_bram_sched.sv
// tb/tb_ntt_bram_sched.sv - self-checking bench for ntt_bram_sched
// Small instance with BRAM and identity butterfly models, plus a full-size instance for timing and counts.
module tb_ntt_bram_sched;
  localparam int LG       = 3;
  localparam int LAT      = 2;
  localparam int N        = 1 << LG;
  localparam int PER      = N + LAT + 1;
  localparam int EXP_DONE = (LG - 1) * PER + N + LAT + 2;
  localparam int BLG      = 9;
  localparam int BLAT     = 4;
  localparam int BN       = 1 << BLG;
  localparam int B_DONE   = (BLG - 1) * (BN + BLAT + 1) + BN + BLAT + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic                    a_start, a_busy, a_done, a_wr_en, a_bf_vld, a_bf_sel;
  logic                    host_wr_en;
  logic [LG-1:0]           host_wr_addr, host_rd_addr, a_wr_addr, a_rd_addr;
  logic [LG-2:0]           a_tw;
  logic [$clog2(LG)-1:0]   a_stg;
  logic [17:0]             host_din;

  logic                    b_start, b_busy, b_done, b_wr_en, b_bf_vld, b_bf_sel;
  logic                    b_host_wr_en;
  logic [BLG-1:0]          b_host_wr_addr, b_host_rd_addr, b_wr_addr, b_rd_addr;
  logic [BLG-2:0]          b_tw;
  logic [$clog2(BLG)-1:0]  b_stg;

  ntt_bram_sched #(.LOGN(LG), .BF_LAT(LAT)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_rd_addr(host_rd_addr),
    .bram_wr_en(a_wr_en), .bram_wr_addr(a_wr_addr), .bram_rd_addr(a_rd_addr),
    .bf_in_valid(a_bf_vld), .bf_in_sel(a_bf_sel), .bf_tw_idx(a_tw), .bf_stage(a_stg)
  );

  ntt_bram_sched #(.LOGN(BLG), .BF_LAT(BLAT)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .host_wr_en(b_host_wr_en), .host_wr_addr(b_host_wr_addr), .host_rd_addr(b_host_rd_addr),
    .bram_wr_en(b_wr_en), .bram_wr_addr(b_wr_addr), .bram_rd_addr(b_rd_addr),
    .bf_in_valid(b_bf_vld), .bf_in_sel(b_bf_sel), .bf_tw_idx(b_tw), .bf_stage(b_stg)
  );

  // BRAM with registered read, identity butterfly of LAT cycles
  logic [17:0] mem [N];
  logic [17:0] rd_dout;
  logic [17:0] bf_pipe [LAT];
  always @(posedge clk) begin
    rd_dout <= mem[a_rd_addr];
    if (a_wr_en) mem[a_wr_addr] <= a_busy ? bf_pipe[LAT-1] : host_din;
    bf_pipe[0] <= rd_dout;
    for (int i = 1; i < LAT; i++) bf_pipe[i] <= bf_pipe[i-1];
  end

  typedef struct { int cyc; int addr; int sel; int tw; int stg; } rd_exp_t;
  typedef struct { int cyc; int addr; } wr_exp_t;
  typedef struct {
    logic wr_en; logic [LG-1:0] wa; logic [LG-1:0] ra;
    logic exp_en; logic [LG-1:0] exp_wa; logic [LG-1:0] exp_ra;
  } mux_vec_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  bit      sb_on = 0;
  int      t0 = 0;
  logic [LG-1:0] prev_rd = '0;

  bit         b_on = 0;
  int         tb0 = 0;
  int         b_wcnt, b_rcnt, b_first;
  logic [BN-1:0]  b_seen;
  logic [BLG-1:0] b_prev_rd = '0;

  mux_vec_t    vecs [4];
  logic [17:0] data [N];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model();
    rd_exp_t r;
    wr_exp_t w;
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < LG; s++)
      for (int j = 0; j < N / 2; j++)
        for (int p = 0; p < 2; p++) begin
          int half, grp, off;
          half   = N >> (s + 1);
          grp    = j / half;
          off    = j % half;
          r.cyc  = 1 + s * PER + 2 * j + p;
          r.addr = grp * 2 * half + off + p * half;
          r.sel  = p;
          r.tw   = (off * (1 << s)) % (N / 2);
          r.stg  = s;
          rd_q.push_back(r);
          w.cyc  = r.cyc + 1 + LAT;
          w.addr = r.addr;
          wr_q.push_back(w);
        end
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (sb_on && a_bf_vld) begin
      if (rd_q.size() == 0) chk("rd_extra", 1, 0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_cycle", rel - 1, e.cyc);
        chk("rd_addr", int'(prev_rd), e.addr);
        chk("rd_sel", int'(a_bf_sel), e.sel);
        chk("rd_tw", int'(a_tw), e.tw);
        chk("rd_stage", int'(a_stg), e.stg);
      end
    end
    if (sb_on && a_busy && a_wr_en) begin
      if (wr_q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_cycle", rel, e.cyc);
        chk("wr_addr", int'(a_wr_addr), e.addr);
      end
    end
    prev_rd = a_rd_addr;
  end

  always @(negedge clk) begin
    if (b_on && b_busy && b_wr_en) begin
      if (b_first < 0) b_first = cyc - tb0;
      chk("b_dup_write", int'(b_seen[b_wr_addr]), 0);
      b_seen[b_wr_addr] = 1'b1;
      b_wcnt++;
      if (b_wcnt % BN == 0) b_seen = '0;
    end
    if (b_on && b_bf_vld) begin
      b_rcnt++;
      chk("b_sel_bit", int'(b_prev_rd[BLG - 1 - int'(b_stg)]), int'(b_bf_sel));
      chk("b_tw_low", int'(b_tw) % (1 << int'(b_stg)), 0);
    end
    b_prev_rd = b_rd_addr;
  end

  task automatic run_a(input bit second_start, input int abort_at);
    push_model();
    tick();
    a_start = 1'b1;
    t0      = cyc;
    sb_on   = 1;
    for (int rel = 1; rel <= EXP_DONE + 3; rel++) begin
      tick();
      a_start      = second_start && (rel == 10);
      host_wr_en   = (rel == 2 || rel == 12 || rel == 13);
      host_wr_addr = 3'd3;
      host_din     = 18'h3ffff;
      if (rel == abort_at) begin
        #2;
        chk("pre_abort_wr_en", int'(a_wr_en), 1);
        chk("pre_abort_valid", int'(a_bf_vld), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_done", int'(a_done), 0);
        chk("abort_wr_en", int'(a_wr_en), 0);
        chk("abort_valid", int'(a_bf_vld), 0);
        sb_on = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_abort_busy", int'(a_busy), 0);
        chk("post_abort_valid", int'(a_bf_vld), 0);
        return;
      end
      @(negedge clk);
      chk("done", int'(a_done), int'(rel == EXP_DONE));
      chk("busy", int'(a_busy), int'(rel <= EXP_DONE));
    end
    host_wr_en = 1'b0;
    sb_on      = 0;
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
  endtask

  task automatic readback();
    for (int i = 0; i < N; i++) begin
      host_rd_addr = LG'(i);
      tick();
      chk("readback", int'(rd_dout), int'(data[i]));
    end
  endtask

  task automatic run_b();
    int done_rel;
    done_rel = -1;
    b_seen   = '0;
    b_wcnt   = 0;
    b_rcnt   = 0;
    b_first  = -1;
    tick();
    b_start = 1'b1;
    tb0     = cyc;
    b_on    = 1;
    tick();
    b_start = 1'b0;
    for (int rel = 1; rel <= B_DONE + 50; rel++) begin
      @(negedge clk);
      if (b_done) begin
        done_rel = rel;
        break;
      end
      tick();
    end
    chk("b_done_cycle", done_rel, B_DONE);
    repeat (2) tick();
    b_on = 0;
    chk("b_busy_end", int'(b_busy), 0);
    chk("b_write_count", b_wcnt, BLG * BN);
    chk("b_read_count", b_rcnt, BLG * BN);
    chk("b_first_write", b_first, 2 + BLAT);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd5, 3'd2, 1'b1, 3'd5, 3'd2};
    vecs[1] = '{1'b0, 3'd7, 3'd0, 1'b0, 3'd7, 3'd0};
    vecs[2] = '{1'b1, 3'd0, 3'd7, 1'b1, 3'd0, 3'd7};
    vecs[3] = '{1'b0, 3'd3, 3'd6, 1'b0, 3'd3, 3'd6};
    for (int i = 0; i < N; i++) data[i] = 18'(1000 + 37 * i);

    a_start = 1'b0; b_start = 1'b0;
    host_wr_en = 1'b0; host_wr_addr = '0; host_rd_addr = '0; host_din = '0;
    b_host_wr_en = 1'b0; b_host_wr_addr = '0; b_host_rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_done", int'(a_done), 0);
    chk("reset_valid", int'(a_bf_vld), 0);
    chk("reset_wr_en", int'(a_wr_en), 0);
    chk("reset_stage", int'(a_stg), 0);
    chk("reset_tw", int'(a_tw), 0);
    chk("reset_b_busy", int'(b_busy), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      host_wr_en   = vecs[k].wr_en;
      host_wr_addr = vecs[k].wa;
      host_rd_addr = vecs[k].ra;
      #1;
      chk("idle_mux_wr_en", int'(a_wr_en), int'(vecs[k].exp_en));
      chk("idle_mux_wr_addr", int'(a_wr_addr), int'(vecs[k].exp_wa));
      chk("idle_mux_rd_addr", int'(a_rd_addr), int'(vecs[k].exp_ra));
      tick();
    end

    for (int i = 0; i < N; i++) begin
      host_wr_en   = 1'b1;
      host_wr_addr = LG'(i);
      host_din     = data[i];
      tick();
    end
    host_wr_en = 1'b0;

    run_a(1'b0, -1);
    readback();
    run_a(1'b1, -1);
    run_a(1'b0, 15);
    run_a(1'b0, -1);
    readback();
    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
